vc_out_scheduler: RTL and testbench
===================================

// Module: vc_out_scheduler
// PURPOSE
//  Wormhole packet scheduler between the per-VC input buffers and a router output port.
//  - Round-robin grant among virtual channels; the grant is locked from head flit to tail flit.
//  - Serialises the granted VC's flits onto one registered valid/ready flit stream, tagged with the source VC id.
//  - Sits between the input-module VC FIFOs and the router output/crossbar stage.
// PARAMETERS
//  FLIT_WIDTH  34  flit width in bits; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] hold the flit type
//  N_VC        2   number of virtual channels (>=2); VC 0 has the lowest index
//  VC_W        $clog2(N_VC)  derived width of the VC id
// PORTS
//  clk           in   1              clock, rising edge
//  arst          in   1              asynchronous reset, active high
//  vc_valid_i    in   N_VC           per-VC flit available at FIFO head
//  vc_flit_i     in   N_VC*FLIT_WIDTH  per-VC head flit; VC k is at [k*FLIT_WIDTH +: FLIT_WIDTH]
//  vc_ready_o    out  N_VC           per-VC pop strobe (one-hot or zero)
//  fout_valid_o  out  1              output flit valid (registered)
//  fout_flit_o   out  FLIT_WIDTH     output flit (registered)
//  fout_vc_id_o  out  VC_W           VC id of the output flit (registered)
//  fout_ready_i  in   1              downstream accepts the flit
//  locked_o      out  1              1 while a multi-flit packet holds the grant
//  err_o         out  1              one-cycle pulse on a protocol violation
// BEHAVIOUR
//  Flit type codes: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
//  Reset (arst=1, asynchronous): all of the following are cleared or zeroed:
//   - outputs fout_valid_o, fout_flit_o, fout_vc_id_o, locked_o, err_o
//   - vc_ready_o is 0; state is IDLE; rr_ptr is 0; lock_vc is 0.
//  Output register:
//   - load_en = !fout_valid_o | fout_ready_i.
//   - The register holds its contents while fout_valid_o=1 and fout_ready_i=0.
//   - fout_valid_o clears on accept when no new flit is loaded.
//   - Latency is 1 cycle from pop to fout_valid_o; throughput is 1 flit/cycle with no bubbles.
//  Pop: vc_ready_o[k] = load_en & grant[k]. A flit transfers on vc_valid_i[k] & vc_ready_o[k].
//  FSM state IDLE:
//   - grant = first set bit of vc_valid_i, searching circularly from rr_ptr.
//   - On a transfer, rr_ptr <= granted+1 (mod N_VC).
//   - Granted type HEAD: go to LOCKED with lock_vc <= granted; locked_o=1 from the next cycle.
//   - Granted type HEAD_TAIL: stay in IDLE.
//   - Granted type BODY or TAIL: forward the flit anyway, pulse err_o, stay in IDLE.
//  FSM state LOCKED:
//   - grant = lock_vc only; other VCs are never popped, even when lock_vc is not valid (the packet stalls).
//   - Transfer of a TAIL: return to IDLE; next arbitration starts at rr_ptr (=lock_vc+1), with no idle cycle.
//   - Transfer of a HEAD or HEAD_TAIL: forward, pulse err_o, stay LOCKED.
//  No grant change occurs while the output is stalled (load_en=0): the grant is held and vc_ready_o=0.
//  Wrap-around: rr_ptr wraps from N_VC-1 to 0.
//  Reset mid-packet: the lock is dropped and the partial packet in the register is discarded; upstream must flush too.
//  err_o is combinational from the registered type check, valid one cycle after the offending pop.
// TESTING
//  T1 reset: assert arst mid-run -> same cycle all outputs 0, state IDLE; after release the first grant goes to VC0 if valid.
//  T2 single-flit RR: VC0 and VC1 each hold 3 HEAD_TAIL flits, fout_ready_i=1 -> output VC order 0,1,0,1,0,1 with no gaps.
//  T3 wormhole lock: VC0 sends HEAD,BODY,BODY,TAIL while VC1 stays valid -> VC1 not popped until the cycle after the TAIL pop; VC1 is the next grant.
//  T4 backpressure: fout_ready_i=0 for 5 cycles mid-packet -> fout_flit_o stable, vc_ready_o=0; on release the flits resume unchanged and in order.
//  T5 lock stall: VC0 HEAD then vc_valid_i[0]=0 for 4 cycles with VC1 valid -> no VC1 pop; locked_o stays 1.
//  T6 protocol error: BODY flit arrives at IDLE -> forwarded with fout_vc_id_o correct, err_o=1 for exactly 1 cycle, state stays IDLE.

Source files
------------

// File: rtl/vc_out_scheduler.sv
// vc_out_scheduler: round-robin wormhole scheduler serialising per-VC flits onto one registered valid/ready stream.
module vc_out_scheduler #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VC = 2,
  localparam int VC_W = $clog2(N_VC)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_VC-1:0]          vc_valid_i,
  input  logic [N_VC*FLIT_WIDTH-1:0] vc_flit_i,
  output logic [N_VC-1:0]          vc_ready_o,
  output logic                     fout_valid_o,
  output logic [FLIT_WIDTH-1:0]    fout_flit_o,
  output logic [VC_W-1:0]          fout_vc_id_o,
  input  logic                     fout_ready_i,
  output logic                     locked_o,
  output logic                     err_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11;
  state_t state, state_n;
  logic [VC_W-1:0] rr_ptr, rr_n, lock_vc, lock_n, gidx;
  logic found, load_en, xfer, bad, err_q;
  logic [FLIT_WIDTH-1:0] sel;
  logic [1:0] ftype;
  // Lowest circular offset from p wins: scan offsets high to low so the last hit is the nearest.
  function automatic logic [VC_W:0] rr_pick(input logic [N_VC-1:0] v, input logic [VC_W-1:0] p);
    int k;
    rr_pick = '0;
    for (int i = N_VC - 1; i >= 0; i--) begin
      k = (int'(p) + i) % N_VC;
      if (v[k[VC_W-1:0]]) rr_pick = {1'b1, k[VC_W-1:0]};
    end
  endfunction
  assign load_en = !fout_valid_o | fout_ready_i;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_vc <= '0;
    end else begin
      state   <= state_n;
      rr_ptr  <= rr_n;
      lock_vc <= lock_n;
    end
  end
  always_comb begin
    {found, gidx} = (state == LOCKED) ? {vc_valid_i[lock_vc], lock_vc} : rr_pick(vc_valid_i, rr_ptr);
    sel = vc_flit_i[int'(gidx)*FLIT_WIDTH +: FLIT_WIDTH];
    ftype = sel[FLIT_WIDTH-1 -: 2];
    xfer = found & load_en;
    state_n = state;
    rr_n = rr_ptr;
    lock_n = lock_vc;
    bad = 1'b0;
    if (xfer && state == IDLE) begin
      rr_n = VC_W'((int'(gidx) + 1) % N_VC);
      lock_n = (ftype == HEAD) ? gidx : lock_vc;
      state_n = (ftype == HEAD) ? LOCKED : IDLE;
      bad = (ftype == BODY) || (ftype == TAIL);
    end else if (xfer) begin
      state_n = (ftype == TAIL) ? IDLE : LOCKED;
      bad = (ftype == HEAD) || (ftype == HEAD_TAIL);
    end
  end
  always_comb begin
    vc_ready_o = (xfer && !arst) ? N_VC'(1) << gidx : '0;
    locked_o = (state == LOCKED);
    err_o = err_q;
  end
  // Output stage: reloads whenever empty or being drained, holds under backpressure.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fout_valid_o <= 1'b0;
      fout_flit_o  <= '0;
      fout_vc_id_o <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= bad;
      if (load_en) begin
        fout_valid_o <= xfer;
        if (xfer) begin
          fout_flit_o  <= sel;
          fout_vc_id_o <= gidx;
        end
      end
    end
  end
endmodule

// File: tb/tb_vc_out_scheduler.sv
// tb_vc_out_scheduler: directed table, reset sequence and randomized run against a queue-based reference model.
module tb_vc_out_scheduler;
  localparam int FW = 34;
  localparam int N = 2;
  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, HT = 2'b11;
  logic clk = 1'b0;
  logic arst;
  logic [N-1:0] vc_valid_i, vc_ready_o;
  logic [N*FW-1:0] vc_flit_i;
  logic fout_valid_o, fout_ready_i, locked_o, err_o;
  logic [FW-1:0] fout_flit_o;
  logic [0:0] fout_vc_id_o;
  int errors = 0, checks = 0;
  vc_out_scheduler #(.FLIT_WIDTH(FW), .N_VC(N)) dut (
    .clk(clk), .arst(arst), .vc_valid_i(vc_valid_i), .vc_flit_i(vc_flit_i),
    .vc_ready_o(vc_ready_o), .fout_valid_o(fout_valid_o), .fout_flit_o(fout_flit_o),
    .fout_vc_id_o(fout_vc_id_o), .fout_ready_i(fout_ready_i), .locked_o(locked_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {
    logic [1:0] v;
    logic [1:0] t0;
    logic [1:0] t1;
    logic       rdy;
    logic [1:0] e_rdy;
    logic       e_fv;
    logic       e_vc;
    logic       e_lk;
    logic       e_err;
  } vec_t;
  vec_t tbl[16];
  logic [FW-1:0] q[N][$];
  logic [FW-1:0] fl[N];
  logic [FW-1:0] m_flit;
  logic [N-1:0] vld, e_rdy;
  logic m_fv, m_err;
  int m_lock, m_ptr, m_vc, g, len;
  logic [1:0] ty;
  task automatic do_reset();
    arst = 1'b1;
    vc_valid_i = '0;
    vc_flit_i = '0;
    fout_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 arst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{2'b11, HT, HT, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, HT, HT, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, HT, HT, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, H,  HT, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{2'b11, B,  HT, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{2'b10, B,  HT, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, B,  HT, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'b11, T,  HT, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{2'b11, T,  HT, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'b11, HT, HT, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{2'b01, B,  HT, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{2'b00, HT, HT, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{2'b10, HT, H,  1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{2'b11, HT, HT, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{2'b11, HT, T,  1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{2'b11, HT, HT, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    chk("rst_fv", fout_valid_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_err", err_o, 0);
    for (int i = 0; i < 16; i++) begin
      vc_valid_i = tbl[i].v;
      vc_flit_i = {tbl[i].t1, 32'(100 + i), tbl[i].t0, 32'(i)};
      fout_ready_i = tbl[i].rdy;
      #1 chk($sformatf("tbl%0d_ready", i), vc_ready_o, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_fv", i), fout_valid_o, tbl[i].e_fv);
      if (tbl[i].e_fv) chk($sformatf("tbl%0d_vc", i), fout_vc_id_o, tbl[i].e_vc);
      chk($sformatf("tbl%0d_locked", i), locked_o, tbl[i].e_lk);
      chk($sformatf("tbl%0d_err", i), err_o, tbl[i].e_err);
    end
    // Reset in the middle of a locked packet, asserted between clock edges.
    vc_valid_i = 2'b01;
    vc_flit_i = {HT, 32'd7, H, 32'd6};
    @(posedge clk);
    #1 chk("pre_rst_locked", locked_o, 1);
    vc_valid_i = 2'b11;
    vc_flit_i = {HT, 32'd9, HT, 32'd8};
    #2 arst = 1'b1;
    #1;
    chk("arst_fv", fout_valid_o, 0);
    chk("arst_flit", fout_flit_o, 0);
    chk("arst_vc", fout_vc_id_o, 0);
    chk("arst_locked", locked_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_ready", vc_ready_o, 0);
    @(posedge clk);
    #2 arst = 1'b0;
    #1 chk("post_rst_ready", vc_ready_o, 2'b01);
    @(posedge clk);
    #1;
    chk("post_rst_vc", fout_vc_id_o, 0);
    chk("post_rst_flit", fout_flit_o, {HT, 32'd8});
    // Randomized run with upstream FIFOs modelled as queues.
    do_reset();
    m_fv = 1'b0; m_err = 1'b0; m_flit = '0; m_vc = 0; m_lock = -1; m_ptr = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (q[k].size() < 4) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) begin
            ty = (len == 1) ? HT : (j == 0) ? H : (j == len - 1) ? T : B;
            if ($urandom_range(0, 24) == 0) ty = 2'($urandom_range(0, 3));
            q[k].push_back({ty, 32'($urandom)});
          end
        end
        vld[k] = (q[k].size() > 0) && ($urandom_range(0, 9) < 8);
        fl[k] = vld[k] ? q[k][0] : {2'($urandom_range(0, 3)), 32'($urandom)};
      end
      vc_valid_i = vld;
      vc_flit_i = {fl[1], fl[0]};
      fout_ready_i = ($urandom_range(0, 9) < 7);
      g = -1;
      if (m_lock >= 0) g = vld[m_lock] ? m_lock : -1;
      else for (int i = N - 1; i >= 0; i--) if (vld[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      if (m_fv && !fout_ready_i) g = -1;
      e_rdy = (g >= 0) ? N'(1) << g : '0;
      #1;
      chk("rnd_ready", vc_ready_o, e_rdy);
      chk("rnd_fv", fout_valid_o, m_fv);
      if (m_fv) begin
        chk("rnd_flit", fout_flit_o, m_flit);
        chk("rnd_vc", fout_vc_id_o, m_vc);
      end
      chk("rnd_locked", locked_o, m_lock >= 0);
      chk("rnd_err", err_o, m_err);
      m_err = 1'b0;
      if (!m_fv || fout_ready_i) m_fv = (g >= 0);
      if (g >= 0) begin
        m_flit = q[g].pop_front();
        m_vc = g;
        ty = m_flit[FW-1 -: 2];
        if (m_lock < 0) begin
          m_ptr = (g + 1) % N;
          m_err = (ty == B) || (ty == T);
          if (ty == H) m_lock = g;
        end else begin
          m_err = (ty == H) || (ty == HT);
          if (ty == T) m_lock = -1;
        end
      end
      @(posedge clk);
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
